axis_fifo_pkt: RTL and testbench
================================

Name: axis_fifo_pkt

Overview:
Parametrised successor to the team's AXI-Stream FIFO. Adds configurable depth and width, tlast transport, a fill-level output, a programmable almost-full threshold, and an optional packet (store-and-forward) mode. It sits between AXI-Stream producer and consumer blocks as a rate and burst buffer. All logic runs in the single aclk domain.

Parameters:
AXI_DATA_WIDTH, 32, tdata width in bits (≥1).
AXI_DATA_DEPTH, 16, number of entries; power of 2, ≥4.
AFULL_MARGIN, 2, fifo_afull asserts when free entries ≤ AFULL_MARGIN (1..DEPTH-1).

Ports:
aclk  in  1  clock, all logic on rising edge.
aresetn  in  1  asynchronous active-low reset.
s_axis_tdata  in  AXI_DATA_WIDTH  write data.
s_axis_tvalid  in  1  write valid.
s_axis_tlast  in  1  last beat of packet.
s_axis_tready  out  1  FIFO can accept a beat.
m_axis_tdata  out  AXI_DATA_WIDTH  read data.
m_axis_tvalid  out  1  read valid.
m_axis_tlast  out  1  last flag stored with the beat.
m_axis_tready  in  1  consumer ready.
fifo_empty  out  1  count == 0.
fifo_half  out  1  count ≥ DEPTH/2.
fifo_afull  out  1  count ≥ DEPTH − AFULL_MARGIN.
fifo_full  out  1  count == DEPTH.
fifo_level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

Behaviour:
- Reset: aresetn low asynchronously clears the read/write pointers, count and packet count. Memory contents are don't-care. While in reset and on release: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, fifo_empty=1, fifo_half/afull/full=0, fifo_level=0. Reset mid-transfer discards all stored beats.
- Storage: circular buffer of {tlast, tdata}. Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit. full = (addr bits equal) and (wrap bits differ); empty = pointers equal. Pointers wrap from DEPTH−1 to 0 and toggle the wrap bit.
- Write beat: s_axis_tvalid && s_axis_tready at a rising edge.
- Read beat: m_axis_tvalid && m_axis_tready at a rising edge.
- s_axis_tready = !fifo_full, combinational from registered state. No write while full, even if a read occurs in the same cycle; tready returns high the cycle after the read.
- Latency: first-word-fall-through. A beat written at edge N drives m_axis_tvalid and m_axis_tdata from cycle N+1. Data and tlast are presented combinationally from the memory at the read pointer.
- AXI rules: m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0. m_axis_tvalid never depends on m_axis_tready.
- Simultaneous read and write when not full and not empty: both complete, and count is unchanged. When empty, a write and no read occur; there is no bypass.
- fifo_level and all flags are registered, updated at the same edge as the pointers, and consistent with each other at every cycle.

Optional Feature:
Macro AXIS_FIFO_PACKET_MODE_EN.
- Defined (store-and-forward):
  - Add a packet counter (width $clog2(DEPTH)+1). It increments on a write beat with tlast=1 and decrements on a read beat with tlast=1. Both events in the same edge leave it unchanged.
  - m_axis_tvalid = !empty && (pkt_count > 0 || fifo_full).
  - The fifo_full term is an oversize-packet escape: a packet longer than DEPTH drains in cut-through fashion rather than deadlocking.
- Undefined: no packet counter; m_axis_tvalid = !empty; tlast is stored and forwarded only.

Test Plan:
- Reset release, then write 0x11,0x22,0x33 with m_axis_tready=0 → fifo_level=3, fifo_empty=0. m_axis_tdata=0x11 one cycle after the first write.
- Write 16 beats (DEPTH=16), no reads → fifo_afull at level 14, fifo_full and s_axis_tready=0 at 16. A 17th beat offered is not accepted. One read → s_axis_tready=1 the next cycle.
- Continuous streaming with tvalid=tready=1 for 100 beats from an incrementing counter → output sequence is identical, level stays constant, and pointers wrap correctly.
- Assert aresetn=0 at level 7 mid-stream → all outputs return to reset values immediately. After release, the first written beat is the first read.
- With AXIS_FIFO_PACKET_MODE_EN, write a 4-beat packet, tlast on beat 4 → m_axis_tvalid stays 0 until the cycle after beat 4. The 4 beats read out with tlast only on the 4th.
- With AXIS_FIFO_PACKET_MODE_EN, write a 20-beat packet into DEPTH=16 with random reader stalls → drains on full, with no hang and all 20 beats in order.

Source files
------------

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FWFT FIFO with {tlast,tdata} storage, a write at edge N is visible at N+1; s_axis_tready = !fifo_full.
// `define AXIS_FIFO_PACKET_MODE_EN to hold m_axis_tvalid until a whole packet is stored (full escapes oversize packets).
module axis_fifo_pkt #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_DATA_DEPTH = 16,
  parameter int AFULL_MARGIN   = 2
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [AXI_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              fifo_empty,
  output logic                              fifo_half,
  output logic                              fifo_afull,
  output logic                              fifo_full,
  output logic [$clog2(AXI_DATA_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(AXI_DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] HALF_LVL  = PW'(AXI_DATA_DEPTH / 2);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AXI_DATA_DEPTH - AFULL_MARGIN);

  typedef struct packed {
    logic                      last;
    logic [AXI_DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t         mem [AXI_DATA_DEPTH];
  beat_t         rd_beat;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic          empty_nxt, full_nxt;
  logic          wr_en, rd_en;

  assign s_axis_tready = !fifo_full;
  assign wr_en         = s_axis_tvalid && !fifo_full;
  assign rd_en         = m_axis_tvalid && m_axis_tready;

  // Output is forced to zero when empty so stale memory never leaks out.
  assign rd_beat      = mem[rd_ptr[AW-1:0]];
  assign m_axis_tdata = fifo_empty ? '0 : rd_beat.data;
  assign m_axis_tlast = !fifo_empty && rd_beat.last;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [PW-1:0] pkt_count;
  logic          pkt_in, pkt_out;

  assign pkt_in  = wr_en && s_axis_tlast;
  assign pkt_out = rd_en && m_axis_tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count <= '0;
    end else if (pkt_in && !pkt_out) begin
      pkt_count <= pkt_count + 1'b1;
    end else if (!pkt_in && pkt_out) begin
      pkt_count <= pkt_count - 1'b1;
    end
  end

  assign m_axis_tvalid = !fifo_empty && ((pkt_count != '0) || fifo_full);
`else
  assign m_axis_tvalid = !fifo_empty;
`endif

  // Power-of-two depth: plain PW-bit increment wraps the address and toggles the wrap bit.
  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(wr_en);
    rd_ptr_nxt = rd_ptr + PW'(rd_en);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) && (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= '{last: s_axis_tlast, data: s_axis_tdata};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      fifo_half  <= 1'b0;
      fifo_afull <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      fifo_empty <= empty_nxt;
      fifo_full  <= full_nxt;
      fifo_half  <= (level_nxt >= HALF_LVL);
      fifo_afull <= (level_nxt >= AFULL_LVL);
    end
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
module tb_axis_fifo_pkt;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [W-1:0] s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         fifo_empty, fifo_half, fifo_afull, fifo_full;
  logic [4:0]   fifo_level;

  int checks = 0;
  int errors = 0;
  int wi, ri;

  always #5 aclk = ~aclk;

  axis_fifo_pkt #(.AXI_DATA_WIDTH(W), .AXI_DATA_DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .fifo_empty(fifo_empty), .fifo_half(fifo_half), .fifo_afull(fifo_afull),
    .fifo_full(fifo_full), .fifo_level(fifo_level)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just an ordered queue of {tlast,tdata} beats.
  logic [W:0] mq[$];
  logic       m_wr, m_rd;
  int         n;

  function automatic bit m_vld();
    bit has_last = 1'b0;
    if (mq.size() == 0) return 1'b0;
    if (!PKT) return 1'b1;
    foreach (mq[i]) if (mq[i][W]) has_last = 1'b1;
    return has_last || (mq.size() == DEPTH);
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mq.delete();
    end else begin
      m_wr = s_axis_tvalid && (mq.size() < DEPTH);
      m_rd = m_vld() && m_axis_tready;
      if (m_rd) void'(mq.pop_front());
      if (m_wr) mq.push_back({s_axis_tlast, s_axis_tdata});
    end
  end

  always @(negedge aclk) begin
    n = mq.size();
    chk("m_tvalid", m_axis_tvalid, m_vld());
    chk("m_tdata",  m_axis_tdata,  n > 0 ? mq[0][W-1:0] : '0);
    chk("m_tlast",  m_axis_tlast,  n > 0 ? mq[0][W] : 1'b0);
    chk("s_tready", s_axis_tready, n < DEPTH);
    chk("level",    fifo_level,    n);
    chk("empty",    fifo_empty,    n == 0);
    chk("full",     fifo_full,     n == DEPTH);
    chk("half",     fifo_half,     n >= DEPTH / 2);
    chk("afull",    fifo_afull,    n >= DEPTH - AFM);
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_tready"}, s_axis_tready, 1'b1);
    chk({nm, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk({nm, "_tdata"},  m_axis_tdata,  '0);
    chk({nm, "_tlast"},  m_axis_tlast,  1'b0);
    chk({nm, "_empty"},  fifo_empty,    1'b1);
    chk({nm, "_flags"},  {fifo_half, fifo_afull, fifo_full}, 3'b000);
    chk({nm, "_level"},  fifo_level,    5'd0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #2 aresetn = 1'b0;
    #1 chk_reset_vals("rst");
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic write_beat(input logic [W-1:0] d, input logic l);
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(negedge aclk);
    chk_reset_vals("init");
    aresetn = 1'b1;

    // First-word-fall-through with three stalled beats.
    write_beat(32'h11, 1'b0);
    chk("fwft_tdata", m_axis_tdata, 32'h11);
    write_beat(32'h22, 1'b0);
    write_beat(32'h33, 1'b0);
    chk("three_level", fifo_level, 5'd3);
    chk("three_empty", fifo_empty, 1'b0);

    // Fill to full; the 17th beat must bounce.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      write_beat(32'h100 + i, 1'b0);
      chk("fill_half",  fifo_half,  (i + 1) >= 8);
      chk("fill_afull", fifo_afull, (i + 1) >= 14);
      chk("fill_full",  fifo_full,  (i + 1) == 16);
    end
    chk("full_tready", s_axis_tready, 1'b0);
    write_beat(32'h99, 1'b0);
    chk("over_level", fifo_level, 5'd16);
    @(negedge aclk); m_axis_tready = 1'b1;
    @(negedge aclk); m_axis_tready = 1'b0;
    chk("reopen_tready", s_axis_tready, 1'b1);
    chk("reopen_level",  fifo_level,    5'd15);

    // Continuous streaming; per-beat tlast keeps packet mode flowing too.
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (i >= 1) begin
        chk("stream_level", fifo_level, 5'd1);
        chk("stream_data",  m_axis_tdata, i - 1);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b1;
      s_axis_tdata  = i;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;

    // Reset at level 7 mid-stream, then the first new beat comes out first.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 32'h70 + i;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("mid_level", fifo_level, 5'd7);
    #2 aresetn = 1'b0;
    #1 chk_reset_vals("mid");
    @(negedge aclk);
    aresetn = 1'b1;
    write_beat(32'hC3, 1'b1);
    chk("post_rst_tdata",  m_axis_tdata,  32'hC3);
    chk("post_rst_tvalid", m_axis_tvalid, 1'b1);

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Store-and-forward: nothing visible until the tlast beat lands.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      write_beat(32'hB0 + b, b == 3);
      chk("pkt4_tvalid", m_axis_tvalid, b == 3);
    end
    for (int b = 0; b < 4; b++) begin
      chk("pkt4_tdata", m_axis_tdata, 32'hB0 + b);
      chk("pkt4_tlast", m_axis_tlast, b == 3);
      m_axis_tready = 1'b1;
      @(negedge aclk);
    end
    m_axis_tready = 1'b0;
    chk("pkt4_empty", fifo_empty, 1'b1);
`endif

    // 20-beat packet through a 16-deep FIFO with a stalling reader.
    do_reset();
    wi = 0; ri = 0;
    for (int c = 0; c < 2000 && ri < 20; c++) begin
      @(negedge aclk);
      s_axis_tvalid = (wi < 20);
      s_axis_tdata  = 32'h200 + wi;
      s_axis_tlast  = (wi == 19);
      if (s_axis_tvalid && s_axis_tready) wi++;
      m_axis_tready = ($urandom_range(0, 2) != 0);
      if (m_axis_tready && m_axis_tvalid) begin
        chk("pkt20_order", m_axis_tdata, 32'h200 + ri);
        ri++;
      end
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    chk("pkt20_count", ri, 20);
    chk("pkt20_drained", fifo_level, 5'd0);

    // Random traffic: write-heavy first half, read-heavy second half.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge aclk);
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      s_axis_tlast  = ($urandom_range(0, 3) == 0);
      m_axis_tready = ($urandom_range(0, 99) < (c < 750 ? 30 : 80));
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    @(negedge aclk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
